// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bundle: redirect/stall control, imem request/response, decode-side instruction handshake.
// master = fetch queue side, slave = environment (execute stage, memory, decode).
interface inst_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          stall_fetch;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [31:0]   imem_req_addr;
    logic          imem_resp_valid;
    logic [31:0]   imem_resp_data;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst_data;
    logic [31:0]   inst_pc;
    logic [CW-1:0] queue_count;

    modport master (
        input  redirect_valid, redirect_pc, stall_fetch,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, queue_count
    );

    modport slave (
        output redirect_valid, redirect_pc, stall_fetch,
        output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, queue_count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetch with PC-tagged DEPTH-entry queue; memory latency L gives inst_valid L+1 cycles after accept.
// Requests stop once buffered + outstanding reaches DEPTH; a redirect flushes the queue and drops stale responses.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    inst_fetch_queue_if.master  fq_bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    ptr_t        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    ptr_t        tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    cnt_t        count_q, count_d, outst_q, outst_d, disc_q, disc_d;

    logic [31:0] fifo_pc   [DEPTH];
    logic [31:0] fifo_inst [DEPTH];
    logic [31:0] tag_pc    [DEPTH];

    logic        req_fire, resp_ok, push, pop, head_vld;
    logic [CW:0] inflight;

    assign inflight = {1'b0, count_q} + {1'b0, outst_q};
    assign head_vld = (count_q != '0);

    // Gating with reset keeps the request bus quiet while the core is held in reset.
    assign fq_bus.imem_req_valid = reset && !fq_bus.stall_fetch && !fq_bus.redirect_valid &&
                                   (inflight < (CW+1)'(DEPTH));
    assign fq_bus.imem_req_addr  = fetch_pc_q;
    assign req_fire = fq_bus.imem_req_valid && fq_bus.imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored entirely.
    assign resp_ok = fq_bus.imem_resp_valid && (outst_q != '0);
    assign push    = resp_ok && (disc_q == '0) && !fq_bus.redirect_valid;
    assign pop     = head_vld && fq_bus.inst_ready && !fq_bus.redirect_valid;

    assign fq_bus.inst_valid  = head_vld;
    assign fq_bus.inst_data   = head_vld ? fifo_inst[rd_ptr_q] : '0;
    assign fq_bus.inst_pc     = head_vld ? fifo_pc[rd_ptr_q]   : '0;
    assign fq_bus.queue_count = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        count_d    = count_q;
        disc_d     = disc_q;
        outst_d    = outst_q + cnt_t'(req_fire) - cnt_t'(resp_ok);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            tag_wr_d   = tag_wr_q + 1'b1;
        end
        if (resp_ok) begin
            tag_rd_d = tag_rd_q + 1'b1;
        end

        if (fq_bus.redirect_valid) begin
            // Everything still in flight after this edge is stale.
            fetch_pc_d = {fq_bus.redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            disc_d     = outst_d;
        end else begin
            if (resp_ok && (disc_q != '0)) begin
                disc_d = disc_q - 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            disc_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            disc_q     <= disc_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and counters above.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]   <= tag_pc[tag_rd_q];
            fifo_inst[wr_ptr_q] <= fq_bus.imem_resp_data;
        end
        if (req_fire) begin
            tag_pc[tag_wr_q] <= fetch_pc_q;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed stimulus for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic rst_n;

    inst_fetch_queue_if #(.DEPTH(DEPTH)) bus_if ();

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk    (clk),
        .reset  (rst_n),
        .fq_bus (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;
    typedef struct {int due; logic [31:0] data;} rsp_t;

    ent_t        m_fifo[$];
    logic [31:0] m_tags[$];
    int          m_disc;
    logic [31:0] m_pc;

    rsp_t        pend[$];
    int          lat;
    int          cyc;
    bit          inj_err;
    bit          inj_now;
    logic [31:0] salt;

    int          n_checks;
    int          n_err;
    int          n_acc;
    logic [31:0] deliv[$];

    logic        cap_rv;
    logic [31:0] cap_addr;
    logic        obs_rv, obs_iv;
    logic [31:0] obs_addr, obs_pc, obs_data, obs_cnt;

    function automatic logic [31:0] mfn(input logic [31:0] a);
        return a ^ salt;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_tags.delete();
        m_disc = 0;
        m_pc   = RESET_PC;
    endtask

    task automatic model_edge();
        bit          fire, keep;
        logic [31:0] tag;
        ent_t        gone;
        if (!rst_n) begin
            model_reset();
            return;
        end
        fire = !bus_if.stall_fetch && !bus_if.redirect_valid &&
               (m_fifo.size() + m_tags.size() < DEPTH) && bus_if.imem_req_ready;
        keep = 1'b0;
        tag  = '0;
        if (bus_if.imem_resp_valid && m_tags.size() > 0) begin
            tag = m_tags.pop_front();
            if (!bus_if.redirect_valid) begin
                if (m_disc > 0) m_disc--;
                else keep = 1'b1;
            end
        end
        if (bus_if.redirect_valid) begin
            m_fifo.delete();
            m_pc   = {bus_if.redirect_pc[31:2], 2'b00};
            m_disc = m_tags.size();
        end else begin
            if (m_fifo.size() > 0 && bus_if.inst_ready) gone = m_fifo.pop_front();
            if (keep) m_fifo.push_back('{tag, mfn(tag)});
            if (fire) begin
                m_tags.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic mem_drive();
        inj_now = 1'b0;
        if (rst_n && pend.size() > 0 && pend[0].due <= cyc + 1) begin
            bus_if.imem_resp_valid = 1'b1;
            bus_if.imem_resp_data  = pend[0].data;
        end else if (rst_n && inj_err && pend.size() == 0) begin
            inj_now = 1'b1;
            bus_if.imem_resp_valid = 1'b1;
            bus_if.imem_resp_data  = $urandom;
        end else begin
            bus_if.imem_resp_valid = 1'b0;
            bus_if.imem_resp_data  = '0;
        end
    endtask

    task automatic mem_edge();
        int due;
        if (!rst_n) begin
            pend.delete();
            return;
        end
        if (bus_if.imem_resp_valid && !inj_now && pend.size() > 0) pend.delete(0);
        if (cap_rv && bus_if.imem_req_ready) begin
            due = cyc + 1 + lat;
            if (pend.size() > 0 && pend[pend.size()-1].due >= due) due = pend[pend.size()-1].due + 1;
            pend.push_back('{due, mfn(cap_addr)});
        end
    endtask

    task automatic compare();
        bit exp_rv;
        exp_rv = rst_n && !bus_if.stall_fetch && !bus_if.redirect_valid &&
                 (m_fifo.size() + m_tags.size() < DEPTH);
        chk("req_valid",   32'(bus_if.imem_req_valid), 32'(exp_rv));
        chk("req_addr",    bus_if.imem_req_addr, m_pc);
        chk("inst_valid",  32'(bus_if.inst_valid), 32'(m_fifo.size() != 0));
        chk("queue_count", 32'(bus_if.queue_count), m_fifo.size());
        if (m_fifo.size() > 0) begin
            chk("inst_pc",   bus_if.inst_pc,   m_fifo[0].pc);
            chk("inst_data", bus_if.inst_data, m_fifo[0].data);
        end else if (!rst_n) begin
            chk("inst_pc_rst",   bus_if.inst_pc,   32'h0);
            chk("inst_data_rst", bus_if.inst_data, 32'h0);
        end
    endtask

    task automatic step();
        mem_drive();
        #1;
        compare();
        cap_rv   = bus_if.imem_req_valid;
        cap_addr = bus_if.imem_req_addr;
        obs_rv   = bus_if.imem_req_valid;
        obs_addr = bus_if.imem_req_addr;
        obs_iv   = bus_if.inst_valid;
        obs_pc   = bus_if.inst_pc;
        obs_data = bus_if.inst_data;
        obs_cnt  = 32'(bus_if.queue_count);
        if (obs_iv && bus_if.inst_ready && !bus_if.redirect_valid) deliv.push_back(obs_pc);
        if (cap_rv && bus_if.imem_req_ready) n_acc++;
        @(posedge clk);
        model_edge();
        mem_edge();
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = '0;
        bus_if.stall_fetch    = 1'b0;
        bus_if.imem_req_ready = 1'b1;
        bus_if.inst_ready     = 1'b1;
        inj_err               = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        pend.delete();
        step();
        step();
        rst_n = 1'b1;
        n_acc = 0;
        deliv.delete();
    endtask

    initial begin
        n_checks = 0; n_err = 0; n_acc = 0; cyc = 0; lat = 1; salt = '0;
        inj_now = 1'b0; cap_rv = 1'b0; cap_addr = '0;
        rst_n = 1'b0;
        idle_inputs();
        bus_if.imem_resp_valid = 1'b0;
        bus_if.imem_resp_data  = '0;
        model_reset();
        @(negedge clk);

        // Reset state
        step();
        chk("rst_req_valid",   32'(obs_rv), 32'h0);
        chk("rst_inst_valid",  32'(obs_iv), 32'h0);
        chk("rst_queue_count", obs_cnt, 32'h0);
        chk("rst_req_addr",    obs_addr, RESET_PC);
        step();
        rst_n = 1'b1;

        // Streaming, L=1, address-as-data
        step(); chk("s1_addr0", obs_addr, 32'h0); chk("s1_iv0", 32'(obs_iv), 32'h0);
        step(); chk("s1_addr1", obs_addr, 32'h4); chk("s1_iv1", 32'(obs_iv), 32'h0);
        step(); chk("s1_addr2", obs_addr, 32'h8); chk("s1_iv2", 32'(obs_iv), 32'h1);
        chk("s1_pc0", obs_pc, 32'h0);
        step(); chk("s1_pc1", obs_pc, 32'h4);
        step(); chk("s1_pc2", obs_pc, 32'h8); chk("s1_data2", obs_data, 32'h8);

        // Full queue backpressure
        apply_reset();
        bus_if.inst_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("s2_accepts", n_acc, 4);
        chk("s2_count", obs_cnt, 32'h4);
        chk("s2_req_off", 32'(obs_rv), 32'h0);
        bus_if.inst_ready = 1'b1;
        step();
        bus_if.inst_ready = 1'b0;
        step();
        chk("s2_new_req", 32'(obs_rv), 32'h1);
        chk("s2_new_addr", obs_addr, 32'h10);
        step();
        chk("s2_one_only", n_acc, 5);

        // Redirect with three in flight, L=3
        apply_reset();
        lat = 3;
        step(); step(); step();
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h103;
        step();
        chk("s3_no_req_redir", 32'(obs_rv), 32'h0);
        bus_if.redirect_valid = 1'b0;
        step();
        chk("s3_redir_addr", obs_addr, 32'h100);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 12 && !seen; i++) begin
                step();
                if (obs_iv) begin
                    seen = 1'b1;
                    chk("s3_first_pc", obs_pc, 32'h100);
                end
            end
            if (!seen) chk("s3_timeout", 32'h0, 32'h1);
        end

        // Redirect coinciding with a response and a pop
        apply_reset();
        lat = 1;
        bus_if.inst_ready = 1'b0;
        step(); step(); step();
        bus_if.inst_ready     = 1'b1;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h40;
        step();
        chk("s4_iv_before", 32'(obs_iv), 32'h1);
        chk("s4_no_req", 32'(obs_rv), 32'h0);
        bus_if.redirect_valid = 1'b0;
        step();
        chk("s4_count_after", obs_cnt, 32'h0);
        chk("s4_addr_after", obs_addr, 32'h40);

        // Stall with two in flight
        apply_reset();
        lat = 3;
        step(); step();
        bus_if.stall_fetch = 1'b1;
        n_acc = 0;
        deliv.delete();
        for (int i = 0; i < 10; i++) step();
        chk("s5_no_accepts", n_acc, 0);
        chk("s5_delivered", deliv.size(), 2);
        if (deliv.size() == 2) begin
            chk("s5_pc0", deliv[0], 32'h0);
            chk("s5_pc1", deliv[1], 32'h4);
        end
        chk("s5_count", obs_cnt, 32'h0);
        bus_if.stall_fetch = 1'b0;

        // Asynchronous reset with entries buffered
        apply_reset();
        lat = 1;
        bus_if.inst_ready = 1'b0;
        step(); step(); step();
        #1;
        chk("s6_count_pre", 32'(bus_if.queue_count), 32'h2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("s6_async_iv",  32'(bus_if.inst_valid), 32'h0);
        chk("s6_async_rv",  32'(bus_if.imem_req_valid), 32'h0);
        chk("s6_async_cnt", 32'(bus_if.queue_count), 32'h0);
        model_reset();
        pend.delete();
        @(negedge clk);
        salt = 32'h5A5A_C3C3;
        step(); step();
        rst_n = 1'b1;
        bus_if.inst_ready = 1'b1;
        step();
        chk("s6_first_req", 32'(obs_rv), 32'h1);
        chk("s6_first_addr", obs_addr, RESET_PC);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            lat                   = $urandom_range(1, 4);
            bus_if.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus_if.inst_ready     = ($urandom_range(0, 2) != 0);
            bus_if.stall_fetch    = ($urandom_range(0, 9) == 0);
            bus_if.redirect_valid = ($urandom_range(0, 19) == 0);
            bus_if.redirect_pc    = $urandom;
            inj_err               = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
